serial_add_scheduler: RTL

SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

---
 rtl/serial_add_scheduler_if.sv | 48 ++++
 rtl/serial_add_scheduler.sv | 104 ++++++++++
 2 files changed

// File: rtl/serial_add_scheduler_if.sv
// Bundles the requester handshakes, the shared full-adder bit lines and the result bus.
// Defining SERIAL_ADD_SCHED_OVF_EN adds the res_ovf result line.
interface serial_add_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_cin;
    logic             req1_cin;
    logic             req0_ready;
    logic             req1_ready;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             res_valid;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
`ifdef SERIAL_ADD_SCHED_OVF_EN
    logic             res_ovf;
`endif

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_cin, req1_cin, fa_sum, fa_cout,
        output req0_ready, req1_ready, fa_a, fa_b, fa_cin,
        output res_valid, res_sum, res_cout, res_id
`ifdef SERIAL_ADD_SCHED_OVF_EN
        , output res_ovf
`endif
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_cin, req1_cin, fa_sum, fa_cout,
        input  req0_ready, req1_ready, fa_a, fa_b, fa_cin,
        input  res_valid, res_sum, res_cout, res_id
`ifdef SERIAL_ADD_SCHED_OVF_EN
        , input res_ovf
`endif
    );
endinterface

// File: rtl/serial_add_scheduler.sv
// Two-requester round-robin scheduler that performs WIDTH-bit additions one bit per cycle
// through a shared external full adder. Optional res_ovf output via SERIAL_ADD_SCHED_OVF_EN.
module serial_add_scheduler #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_add_scheduler_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q, res_sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, id_q, last_q, res_cout_q, res_id_q;
    logic             grant0, grant1, xfer0, xfer1, last_bit;
`ifdef SERIAL_ADD_SCHED_OVF_EN
    logic             res_ovf_q;
`endif

    // last_q names the requester granted most recently; the other one wins a tie.
    assign grant0   = bus.req0_valid && (!bus.req1_valid || last_q);
    assign grant1   = bus.req1_valid && (!bus.req0_valid || !last_q);
    assign xfer0    = (state_q == IDLE) && !rst && grant0;
    assign xfer1    = (state_q == IDLE) && !rst && grant1;
    assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d        = state_q;
        bus.req0_ready = xfer0;
        bus.req1_ready = xfer1;
        bus.fa_a       = 1'b0;
        bus.fa_b       = 1'b0;
        bus.fa_cin     = 1'b0;
        bus.res_valid  = 1'b0;
        case (state_q)
            IDLE: if (xfer0 || xfer1) state_d = RUN;
            RUN: begin
                bus.fa_a   = a_sh_q[0];
                bus.fa_b   = b_sh_q[0];
                bus.fa_cin = carry_q;
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                bus.res_valid = !rst;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_q      <= '0;
            res_sum_q  <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            res_cout_q <= 1'b0;
            res_id_q   <= 1'b0;
`ifdef SERIAL_ADD_SCHED_OVF_EN
            res_ovf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (xfer0 || xfer1) begin
                a_sh_q  <= xfer1 ? bus.req1_a : bus.req0_a;
                b_sh_q  <= xfer1 ? bus.req1_b : bus.req0_b;
                carry_q <= xfer1 ? bus.req1_cin : bus.req0_cin;
                cnt_q   <= '0;
                id_q    <= xfer1;
            end else if (state_q == RUN) begin
                a_sh_q  <= a_sh_q >> 1;
                b_sh_q  <= b_sh_q >> 1;
                sum_q   <= {bus.fa_sum, sum_q[WIDTH-1:1]};
                carry_q <= bus.fa_cout;
                cnt_q   <= cnt_q + CW'(1);
                // Publish on the final bit so the result lines stay stable during the next run.
                if (last_bit) begin
                    res_sum_q  <= {bus.fa_sum, sum_q[WIDTH-1:1]};
                    res_cout_q <= bus.fa_cout;
                    res_id_q   <= id_q;
`ifdef SERIAL_ADD_SCHED_OVF_EN
                    res_ovf_q  <= carry_q ^ bus.fa_cout;
`endif
                end
            end
            if (state_q == DONE) last_q <= id_q;
        end
    end

    assign bus.res_sum  = res_sum_q;
    assign bus.res_cout = res_cout_q;
    assign bus.res_id   = res_id_q;
`ifdef SERIAL_ADD_SCHED_OVF_EN
    assign bus.res_ovf  = res_ovf_q;
`endif
endmodule
